// File: rtl/sd_clk_engine_if.sv
// SD clock engine control/status bundle between the SD FSMs (master) and the clock engine (slave).
interface sd_clk_engine_if #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned WCNT_W    = 16
);
  localparam int unsigned BIDX_W = $clog2(WORD_BITS);

  // Requests from the command/data FSMs
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div;
  logic [WCNT_W-1:0] word_count;
  logic              clear_word;

  // Clock and timing status toward the pads and FSMs
  logic              sdclk;
  logic              rise_stb;
  logic              fall_stb;
  logic              shift_enable;
  logic [BIDX_W-1:0] bit_index;
  logic              word_received;
  logic              xfer_done;
  logic              busy;

  modport slave (
    input  start, stop, div, word_count, clear_word,
    output sdclk, rise_stb, fall_stb, shift_enable, bit_index,
           word_received, xfer_done, busy
  );

  modport master (
    output start, stop, div, word_count, clear_word,
    input  sdclk, rise_stb, fall_stb, shift_enable, bit_index,
           word_received, xfer_done, busy
  );
endinterface

// File: rtl/sd_clk_engine.sv
// SD-bus clock engine: programmable 50%-duty SDCLK, bit/word strobes, glitch-free start/stop.
module sd_clk_engine #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned WCNT_W    = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  sd_clk_engine_if.slave   bus
);

  localparam int unsigned BIDX_W = $clog2(WORD_BITS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIDX_W-1:0] bit_q, bit_d;
  logic [WCNT_W-1:0] words_q, words_d;
  logic              sdclk_q, sdclk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              wrecv_q, wrecv_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              term_c;
  logic              accept_c;
  logic              run_c;
  logic              rise_now_c;
  logic              word_end_c;
  logic              last_word_c;

  // Phase terminal, start acceptance and bit/word boundary decode
  always_comb begin
    term_c      = (cnt_q == div_q);
    accept_c    = (state_q == ST_IDLE) && start_q;
    run_c       = (state_q == ST_RUN) && !bus.stop;
    rise_now_c  = run_c && term_c && !sdclk_q;
    word_end_c  = rise_now_c && !bus.clear_word &&
                  (bit_q == BIDX_W'(WORD_BITS - 1));
    last_word_c = word_end_c && (words_q == WCNT_W'(1));
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop || last_word_c) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        // Low level: leave at once; high level: leave on the falling edge
        if (!sdclk_q || term_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the divider, SDCLK, strobes and bit/word counters
  always_comb begin
    start_d = bus.start && (state_q == ST_IDLE) && !start_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    words_d = words_q;
    sdclk_d = sdclk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    wrecv_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        sdclk_d = 1'b0;
        cnt_d   = '0;
      end
      ST_RUN, ST_STOPPING: begin
        // A low phase only advances while running, so no rise once stopping
        if (sdclk_q || run_c) begin
          if (term_c) begin
            cnt_d   = '0;
            sdclk_d = !sdclk_q;
            if (sdclk_q) begin
              fall_d = 1'b1;
              if (run_c) div_d = bus.div;
            end else begin
              rise_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end
      default: begin
        sdclk_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // clear_word overrides the bit increment and suppresses word strobes
    if (bus.clear_word) begin
      bit_d = '0;
    end else if (rise_now_c) begin
      if (word_end_c) begin
        bit_d   = '0;
        wrecv_d = 1'b1;
        if (words_q != '0) begin
          words_d = words_q - WCNT_W'(1);
          done_d  = last_word_c;
        end
      end else begin
        bit_d = bit_q + BIDX_W'(1);
      end
    end

    if (accept_c) begin
      div_d   = bus.div;
      words_d = bus.word_count;
      bit_d   = '0;
      cnt_d   = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      words_q <= '0;
      sdclk_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      wrecv_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      words_q <= words_d;
      sdclk_q <= sdclk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      wrecv_q <= wrecv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sdclk         = sdclk_q;
  assign bus.rise_stb      = rise_q;
  assign bus.fall_stb      = fall_q;
  assign bus.shift_enable  = rise_q;
  assign bus.bit_index     = bit_q;
  assign bus.word_received = wrecv_q;
  assign bus.xfer_done     = done_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_sd_clk_engine.sv
// Directed bench for sd_clk_engine with hand-computed expectations.
module tb_sd_clk_engine;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  sd_clk_engine_if #(.DIV_W(8), .WORD_BITS(8), .WCNT_W(16)) bus ();

  sd_clk_engine #(.DIV_W(8), .WORD_BITS(8), .WCNT_W(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int nr;
    int done_at;
    int ended;
    int seen_busy;

    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.div = 8'd0;
    bus.word_count = 16'd0;
    bus.clear_word = 1'b0;

    // Reset state
    tick_n(3);
    chk("rst_sdclk", 32'(bus.sdclk), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rise", 32'(bus.rise_stb), 0);
    chk("rst_fall", 32'(bus.fall_stb), 0);
    chk("rst_bit", 32'(bus.bit_index), 0);
    chk("rst_wrecv", 32'(bus.word_received), 0);
    chk("rst_done", 32'(bus.xfer_done), 0);
    n_rst = 1'b1;
    tick_n(2);
    chk("idle_busy", 32'(bus.busy), 0);

    // div=0, two words: 16 rises, period 2
    bus.div = 8'd0;
    bus.word_count = 16'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_e0_busy", 32'(bus.busy), 0);
    tick();
    chk("t1_e1_busy", 32'(bus.busy), 1);
    chk("t1_e1_sdclk", 32'(bus.sdclk), 0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk("t1_rise_sdclk", 32'(bus.sdclk), 1);
      chk("t1_rise_stb", 32'(bus.rise_stb), 1);
      chk("t1_shift_en", 32'(bus.shift_enable), 1);
      chk("t1_bit_index", 32'(bus.bit_index), 32'(k % 8));
      chk("t1_word_recv", 32'(bus.word_received), 32'((k % 8) == 0));
      chk("t1_xfer_done", 32'(bus.xfer_done), 32'(k == 16));
      tick();
      chk("t1_fall_sdclk", 32'(bus.sdclk), 0);
      chk("t1_fall_stb", 32'(bus.fall_stb), 1);
      chk("t1_fall_norise", 32'(bus.rise_stb), 0);
      chk("t1_busy", 32'(bus.busy), 32'(k < 16));
      if (k < 16) tick();
    end
    tick_n(3);
    chk("t1_end_sdclk", 32'(bus.sdclk), 0);
    chk("t1_end_busy", 32'(bus.busy), 0);
    chk("t1_end_rise", 32'(bus.rise_stb), 0);

    // div=2, endless transfer, stop during the high phase after 5 rises
    bus.div = 8'd2;
    bus.word_count = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick_n(2);
    chk("t2_first_low", 32'(bus.sdclk), 0);
    tick();
    for (int r = 1; r <= 5; r++) begin
      chk("t2_rise_stb", 32'(bus.rise_stb), 1);
      chk("t2_rise_sdclk", 32'(bus.sdclk), 1);
      chk("t2_bit_index", 32'(bus.bit_index), 32'(r));
      if (r < 5) begin
        tick_n(2);
        chk("t2_high3", 32'(bus.sdclk), 1);
        tick();
        chk("t2_fall_stb", 32'(bus.fall_stb), 1);
        chk("t2_fall_sdclk", 32'(bus.sdclk), 0);
        tick_n(2);
        chk("t2_low3", 32'(bus.sdclk), 0);
        chk("t2_low3_norise", 32'(bus.rise_stb), 0);
        tick();
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t2_stop_high", 32'(bus.sdclk), 1);
    chk("t2_stop_busy", 32'(bus.busy), 1);
    tick();
    chk("t2_stop_high2", 32'(bus.sdclk), 1);
    chk("t2_stop_nofall", 32'(bus.fall_stb), 0);
    tick();
    chk("t2_last_fall", 32'(bus.fall_stb), 1);
    chk("t2_last_sdclk", 32'(bus.sdclk), 0);
    chk("t2_last_busy", 32'(bus.busy), 0);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rise_stb || bus.sdclk) nr++;
    end
    chk("t2_no_6th_rise", 32'(nr), 0);

    // div 1 -> 3 during a high phase
    bus.div = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("t3_low", 32'(bus.sdclk), 0);
    tick();
    chk("t3_rise", 32'(bus.rise_stb), 1);
    bus.div = 8'd3;
    tick();
    chk("t3_high_keep", 32'(bus.sdclk), 1);
    chk("t3_high_nofall", 32'(bus.fall_stb), 0);
    tick();
    chk("t3_fall_at2", 32'(bus.fall_stb), 1);
    tick_n(3);
    chk("t3_low4", 32'(bus.sdclk), 0);
    chk("t3_low4_norise", 32'(bus.rise_stb), 0);
    tick();
    chk("t3_rise_at4", 32'(bus.rise_stb), 1);
    tick_n(3);
    chk("t3_high4", 32'(bus.sdclk), 1);
    chk("t3_high4_nofall", 32'(bus.fall_stb), 0);
    tick();
    chk("t3_fall_at4", 32'(bus.fall_stb), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t3_stopping_busy", 32'(bus.busy), 1);
    tick();
    chk("t3_idle_busy", 32'(bus.busy), 0);

    // clear_word on the rise that would complete a word
    bus.div = 8'd0;
    bus.word_count = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= 6; k++) tick_n(2);
    chk("t4_bit7", 32'(bus.bit_index), 7);
    chk("t4_bit7_rise", 32'(bus.rise_stb), 1);
    tick();
    bus.clear_word = 1'b1;
    tick();
    bus.clear_word = 1'b0;
    chk("t4_clr_rise", 32'(bus.rise_stb), 1);
    chk("t4_clr_bit", 32'(bus.bit_index), 0);
    chk("t4_clr_nowrecv", 32'(bus.word_received), 0);
    tick_n(2);
    chk("t4_next_rise", 32'(bus.rise_stb), 1);
    chk("t4_next_bit", 32'(bus.bit_index), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick_n(3);
    chk("t4_idle_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a high phase
    bus.div = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick_n(3);
    chk("t5_rise", 32'(bus.rise_stb), 1);
    tick();
    chk("t5_high", 32'(bus.sdclk), 1);
    #1;
    n_rst = 1'b0;
    #1;
    chk("t5_rst_sdclk", 32'(bus.sdclk), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_rise", 32'(bus.rise_stb), 0);
    chk("t5_rst_fall", 32'(bus.fall_stb), 0);
    chk("t5_rst_bit", 32'(bus.bit_index), 0);
    chk("t5_rst_shift", 32'(bus.shift_enable), 0);
    tick_n(2);
    n_rst = 1'b1;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rise_stb || bus.sdclk || bus.busy) nr++;
    end
    chk("t5_stays_idle", 32'(nr), 0);

    // start while busy is ignored: one word of 8 bits completes normally
    bus.div = 8'd1;
    bus.word_count = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nr = 0;
    done_at = 0;
    ended = 0;
    seen_busy = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 4) begin
        bus.word_count = 16'd3;
        bus.start = 1'b1;
      end
      if (cyc == 5) bus.start = 1'b0;
      tick();
      if (bus.rise_stb) nr++;
      if (bus.xfer_done) done_at = nr;
      if (bus.busy) seen_busy = 1;
      if (seen_busy != 0 && !bus.busy) begin
        ended = 1;
        break;
      end
    end
    chk("t6_ended", 32'(ended), 1);
    chk("t6_rises", 32'(nr), 8);
    chk("t6_done_at", 32'(done_at), 8);
    tick_n(4);
    chk("t6_no_restart", 32'(bus.busy), 0);

    // start together with stop in IDLE: start wins
    bus.word_count = 16'd0;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    tick();
    chk("t6_ss_busy", 32'(bus.busy), 1);
    tick_n(2);
    chk("t6_ss_rise", 32'(bus.rise_stb), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick_n(4);
    chk("t6_ss_stopped", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
